// File: rtl/sbus_arb.sv
// Round-robin arbiter funnelling N_MST request/ack masters onto one slave port.
// Masters get a one-cycle ack, or an err pulse if the slave stalls past TMO cycles.
module sbus_arb #(
  parameter int N_MST  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TMO    = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_MST-1:0]            m_req,
  input  logic [N_MST*ADDR_W-1:0]     m_addr,
  input  logic [N_MST-1:0]            m_we,
  input  logic [N_MST*DATA_W/8-1:0]   m_wstrb,
  input  logic [N_MST*DATA_W-1:0]     m_wdata,
  output logic [N_MST-1:0]            m_ack,
  output logic [N_MST-1:0]            m_err,
  output logic [DATA_W-1:0]           m_rdata,
  output logic                        s_req,
  output logic [ADDR_W-1:0]           s_addr,
  output logic                        s_we,
  output logic [DATA_W/8-1:0]         s_wstrb,
  output logic [DATA_W-1:0]           s_wdata,
  input  logic                        s_ack,
  input  logic [DATA_W-1:0]           s_rdata,
  output logic [$clog2(N_MST)-1:0]    grant
);

  localparam int GW = $clog2(N_MST);
  localparam int SW = DATA_W / 8;
  localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [GW-1:0] LAST = GW'(N_MST - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state;
  logic [GW-1:0]      rr_ptr;
  logic [TW-1:0]      tmo_cnt;
  logic               found;
  logic [GW-1:0]      pick;
  logic [GW-1:0]      rr_next;
  logic [N_MST-1:0]   grant_oh;
  logic               tmo_hit;

  // First requester at or after rr_ptr, wrapping modulo N_MST.
  always_comb begin : arb_scan
    int            idx;
    logic [GW-1:0] cand;
    idx   = 0;
    cand  = '0;
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < N_MST; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_MST) idx = idx - N_MST;
      cand = GW'(idx);
      if (!found && m_req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign rr_next  = (grant == LAST) ? '0 : grant + GW'(1);
  assign grant_oh = {{(N_MST-1){1'b0}}, 1'b1} << grant;
  assign tmo_hit  = (TMO > 0) && (tmo_cnt == TW'(TMO - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      grant   <= '0;
      tmo_cnt <= '0;
      s_req   <= 1'b0;
      s_addr  <= '0;
      s_we    <= 1'b0;
      s_wstrb <= '0;
      s_wdata <= '0;
      m_ack   <= '0;
      m_err   <= '0;
      m_rdata <= '0;
    end else begin
      m_ack <= '0;
      m_err <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            state   <= BUSY;
            s_req   <= 1'b1;
            grant   <= pick;
            tmo_cnt <= '0;
            s_addr  <= m_addr[pick*ADDR_W +: ADDR_W];
            s_we    <= m_we[pick];
            s_wstrb <= m_wstrb[pick*SW +: SW];
            s_wdata <= m_wdata[pick*DATA_W +: DATA_W];
          end
        end
        BUSY: begin
          // An ack landing on the expiry cycle still completes normally.
          if (s_ack) begin
            m_rdata <= s_rdata;
            m_ack   <= grant_oh;
            s_req   <= 1'b0;
            rr_ptr  <= rr_next;
            state   <= DONE;
          end else if (tmo_hit) begin
            m_err   <= grant_oh;
            s_req   <= 1'b0;
            rr_ptr  <= rr_next;
            state   <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sbus_arb.sv
// Directed bench: dut_a (2 masters, no timeout) and dut_b (4 masters, TMO=8).
module tb_sbus_arb;

  logic clk;
  logic rst;

  logic [1:0]   a_m_req, a_m_we, a_m_ack, a_m_err;
  logic [63:0]  a_m_addr, a_m_wdata;
  logic [7:0]   a_m_wstrb;
  logic [31:0]  a_m_rdata, a_s_addr, a_s_wdata, a_s_rdata;
  logic         a_s_req, a_s_we, a_s_ack;
  logic [3:0]   a_s_wstrb;
  logic [0:0]   a_grant;

  logic [3:0]   b_m_req, b_m_we, b_m_ack, b_m_err;
  logic [127:0] b_m_addr, b_m_wdata;
  logic [15:0]  b_m_wstrb;
  logic [31:0]  b_m_rdata, b_s_addr, b_s_wdata, b_s_rdata;
  logic         b_s_req, b_s_we, b_s_ack;
  logic [3:0]   b_s_wstrb;
  logic [1:0]   b_grant;

  int n_chk  = 0;
  int n_pass = 0;

  sbus_arb #(.N_MST(2), .ADDR_W(32), .DATA_W(32), .TMO(0)) dut_a (
    .clk(clk), .rst(rst),
    .m_req(a_m_req), .m_addr(a_m_addr), .m_we(a_m_we), .m_wstrb(a_m_wstrb), .m_wdata(a_m_wdata),
    .m_ack(a_m_ack), .m_err(a_m_err), .m_rdata(a_m_rdata),
    .s_req(a_s_req), .s_addr(a_s_addr), .s_we(a_s_we), .s_wstrb(a_s_wstrb), .s_wdata(a_s_wdata),
    .s_ack(a_s_ack), .s_rdata(a_s_rdata), .grant(a_grant)
  );

  sbus_arb #(.N_MST(4), .ADDR_W(32), .DATA_W(32), .TMO(8)) dut_b (
    .clk(clk), .rst(rst),
    .m_req(b_m_req), .m_addr(b_m_addr), .m_we(b_m_we), .m_wstrb(b_m_wstrb), .m_wdata(b_m_wdata),
    .m_ack(b_m_ack), .m_err(b_m_err), .m_rdata(b_m_rdata),
    .s_req(b_s_req), .s_addr(b_s_addr), .s_we(b_s_we), .s_wstrb(b_s_wstrb), .s_wdata(b_s_wdata),
    .s_ack(b_s_ack), .s_rdata(b_s_rdata), .grant(b_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every drive and sample happens 1 ns after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [31:0] last_rd;

    rst = 1'b1;
    a_m_req = '0; a_m_we = '0; a_m_addr = '0; a_m_wdata = '0; a_m_wstrb = '0;
    a_s_ack = 1'b0; a_s_rdata = '0;
    b_m_req = '0; b_m_we = '0; b_m_addr = '0; b_m_wdata = '0; b_m_wstrb = '0;
    b_s_ack = 1'b0; b_s_rdata = '0;
    tick();
    tick();
    chk("rst_a_sreq",   a_s_req,   0);
    chk("rst_a_saddr",  a_s_addr,  0);
    chk("rst_a_grant",  a_grant,   0);
    chk("rst_a_mack",   a_m_ack,   0);
    chk("rst_a_mrdata", a_m_rdata, 0);
    chk("rst_b_sreq",   b_s_req,   0);
    chk("rst_b_merr",   b_m_err,   0);
    chk("rst_b_swdata", b_s_wdata, 0);
    rst = 1'b0;
    tick();
    chk("idle_a_sreq", a_s_req, 0);

    // Master 0 read, slave responds two cycles after s_req rises.
    a_m_addr[31:0] = 32'h0000_1000;
    a_m_req = 2'b01;
    tick();
    chk("rd_sreq",  a_s_req,  1);
    chk("rd_saddr", a_s_addr, 32'h1000);
    chk("rd_grant", a_grant,  0);
    chk("rd_swe",   a_s_we,   0);
    tick();
    chk("rd_noack_early", a_m_ack, 0);
    tick();
    a_s_ack = 1'b1; a_s_rdata = 32'hDEAD_BEEF;
    tick();
    a_s_ack = 1'b0; a_s_rdata = '0;
    chk("rd_mack",   a_m_ack,   2'b01);
    chk("rd_mrdata", a_m_rdata, 32'hDEAD_BEEF);
    chk("rd_sreq_lo", a_s_req,  0);
    a_m_req = 2'b00;
    tick();
    chk("rd_mack_once", a_m_ack, 0);

    // Master 1 write wins (rr_ptr=1); master 0 fiddles its inputs meanwhile.
    a_m_addr  = {32'h0000_2000, 32'h0000_3000};
    a_m_we    = 2'b10;
    a_m_wstrb = {4'b0011, 4'b1111};
    a_m_wdata = {32'h1234_5678, 32'h0BAD_F00D};
    a_m_req   = 2'b11;
    tick();
    chk("wr_grant", a_grant,   1);
    chk("wr_saddr", a_s_addr,  32'h2000);
    chk("wr_swe",   a_s_we,    1);
    chk("wr_strb",  a_s_wstrb, 4'b0011);
    chk("wr_wdata", a_s_wdata, 32'h1234_5678);
    a_m_addr[31:0]  = 32'hAAAA_0000;
    a_m_wdata[31:0] = 32'h5555_AAAA;
    a_m_we[0]       = 1'b1;
    a_m_wstrb[3:0]  = 4'b1000;
    tick();
    tick();
    chk("hold_saddr", a_s_addr,  32'h2000);
    chk("hold_strb",  a_s_wstrb, 4'b0011);
    chk("hold_wdata", a_s_wdata, 32'h1234_5678);
    chk("hold_sreq",  a_s_req,   1);
    a_s_ack = 1'b1;
    tick();
    a_s_ack = 1'b0;
    chk("wr_mack",      a_m_ack, 2'b10);
    chk("done_no_sreq", a_s_req, 0);
    a_m_req = 2'b01;
    tick();
    chk("idle_no_sreq", a_s_req, 0);
    tick();
    chk("m0_grant", a_grant,   0);
    chk("m0_saddr", a_s_addr,  32'hAAAA_0000);
    chk("m0_strb",  a_s_wstrb, 4'b1000);
    a_s_ack = 1'b1; a_s_rdata = 32'h77;
    tick();
    chk("m0_mack", a_m_ack, 2'b01);
    // Keep s_ack high through DONE and IDLE: it must be ignored there.
    a_s_rdata = 32'h99;
    a_m_req = 2'b00;
    tick();
    chk("stray_ack_done", a_m_rdata, 32'h77);
    tick();
    chk("stray_ack_idle_rd",  a_m_rdata, 32'h77);
    chk("stray_ack_idle_ack", a_m_ack,   0);
    a_s_ack = 1'b0; a_s_rdata = '0;

    // Four masters requesting continuously, slave acks immediately.
    for (int i = 0; i < 4; i++) b_m_addr[i*32 +: 32] = 32'h100 * (i + 1);
    b_m_req = 4'hF;
    last_rd = '0;
    for (int it = 0; it < 5; it++) begin
      tick();
      chk($sformatf("rr_grant_%0d", it), b_grant,  it % 4);
      chk($sformatf("rr_saddr_%0d", it), b_s_addr, 32'h100 * ((it % 4) + 1));
      b_s_ack = 1'b1; b_s_rdata = 32'hA000 + it;
      last_rd = 32'hA000 + it;
      tick();
      b_s_ack = 1'b0;
      chk($sformatf("rr_mack_%0d", it), b_m_ack, 4'b0001 << (it % 4));
      if (it == 4) b_m_req = 4'h0;
      tick();
      chk($sformatf("rr_gap_%0d", it), b_s_req, 0);
    end

    // Timeout: masters 0 and 2 request, rr_ptr=1 so master 2 goes first.
    b_m_req = 4'b0101;
    tick();
    chk("tmo_grant", b_grant, 2);
    cnt = 1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (b_s_req) cnt++;
      else break;
    end
    chk("tmo_sreq_cycles", cnt, 8);
    chk("tmo_merr",   b_m_err,   4'b0100);
    chk("tmo_mack",   b_m_ack,   0);
    chk("tmo_mrdata", b_m_rdata, last_rd);
    b_m_req = 4'b0001;
    tick();
    chk("tmo_err_once", b_m_err, 0);
    tick();
    chk("tmo_next_grant", b_grant, 0);
    chk("tmo_next_sreq",  b_s_req, 1);

    // Ack on the 8th BUSY cycle beats the timeout.
    repeat (7) tick();
    chk("edge_sreq_8th", b_s_req, 1);
    b_s_ack = 1'b1; b_s_rdata = 32'hCAFE_F00D;
    tick();
    b_s_ack = 1'b0;
    chk("edge_mack",   b_m_ack,   4'b0001);
    chk("edge_merr",   b_m_err,   0);
    chk("edge_mrdata", b_m_rdata, 32'hCAFE_F00D);
    b_m_req = 4'b0000;
    tick();

    // Reset mid-BUSY, then a late slave ack.
    b_m_req = 4'b1000;
    tick();
    chk("rb_grant", b_grant, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    b_m_req = 4'b0000;
    b_s_ack = 1'b1; b_s_rdata = 32'h1111;
    chk("rb_sreq",   b_s_req,   0);
    chk("rb_grant0", b_grant,   0);
    chk("rb_saddr",  b_s_addr,  0);
    chk("rb_mack",   b_m_ack,   0);
    chk("rb_merr",   b_m_err,   0);
    chk("rb_mrdata", b_m_rdata, 0);
    tick();
    b_s_ack = 1'b0; b_s_rdata = '0;
    chk("late_ack_mack",   b_m_ack,   0);
    chk("late_ack_mrdata", b_m_rdata, 0);
    chk("late_ack_sreq",   b_s_req,   0);
    b_m_req = 4'b1001;
    tick();
    chk("post_rst_grant", b_grant, 0);
    chk("post_rst_sreq",  b_s_req, 1);
    b_s_ack = 1'b1;
    tick();
    b_s_ack = 1'b0;
    chk("post_rst_mack", b_m_ack, 4'b0001);
    b_m_req = 4'b0000;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sbus_arb.md
SBUS_ARB -- requirements
Module: sbus_arb

Interface
REQ-001 Parameter N_MST, default 2: number of master channels, legal range 2..8.
REQ-002 Parameter ADDR_W, default 32: address width.
REQ-003 Parameter DATA_W, default 32: data width; strobe width is DATA_W/8.
REQ-004 Parameter TMO, default 0: slave timeout in cycles; 0 disables the timeout.
REQ-005 clk  in  1  the single clock; all state changes on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 m_req  in  N_MST  per-master request, held high until that master's ack or err.
REQ-008 m_addr  in  N_MST*ADDR_W  packed per-master address; master i occupies slice i.
REQ-009 m_we  in  N_MST  per-master write enable.
REQ-010 m_wstrb  in  N_MST*DATA_W/8  packed per-master byte strobes.
REQ-011 m_wdata  in  N_MST*DATA_W  packed per-master write data.
REQ-012 m_ack  out  N_MST  one-cycle completion pulse to the granted master.
REQ-013 m_err  out  N_MST  one-cycle timeout-error pulse to the granted master.
REQ-014 m_rdata  out  DATA_W  registered read data, shared by all masters, valid with m_ack.
REQ-015 s_req  out  1  request to the downstream slave.
REQ-016 s_addr, s_we, s_wstrb, s_wdata  out  ADDR_W, 1, DATA_W/8, DATA_W  registered copy of the granted master's request.
REQ-017 s_ack  in  1  slave completion pulse.
REQ-018 s_rdata  in  DATA_W  slave read data, valid with s_ack.
REQ-019 grant  out  $clog2(N_MST)  index of the current or most recent owner.

Function
REQ-020 FSM states: IDLE, BUSY, DONE.
REQ-021 IDLE, any m_req high: select the first requester at or after rr_ptr, scanning upward modulo N_MST; latch its addr/we/wstrb/wdata into s_* and its index into grant; next state BUSY.
REQ-022 IDLE, no m_req high: stay IDLE; s_req low.
REQ-023 s_req is high exactly while in BUSY: request seen in cycle c drives s_req in cycle c+1.
REQ-024 s_* payload holds constant throughout BUSY, regardless of master input changes.
REQ-025 BUSY, s_ack high: capture s_rdata into m_rdata; pulse m_ack[grant] in the next cycle; next state DONE.
REQ-026 DONE lasts exactly one cycle with no grant; then IDLE. This prevents regranting a master that still holds m_req in its ack cycle.
REQ-027 On leaving BUSY, rr_ptr becomes (grant+1) modulo N_MST; wrap from N_MST-1 to 0.
REQ-028 Timeout counter clears on entry to BUSY and increments each BUSY cycle without s_ack.
REQ-029 TMO>0 and counter reaches TMO-1 without s_ack: s_req drops; m_err[grant] pulses next cycle; m_rdata unchanged; next state DONE; rr_ptr advances.
REQ-030 s_ack in the same cycle as timeout expiry: the ack wins; no err.
REQ-031 s_ack while in IDLE or DONE: ignored, with no output change.
REQ-032 Master dropping m_req during BUSY: the transaction completes normally and the ack/err is still delivered.
REQ-033 At most one of m_ack/m_err bits is high in any cycle, and never both.
REQ-034 Best-case round trip: 3 cycles (request, s_req with s_ack, m_ack), plus 1 DONE cycle before the next grant.

Reset
REQ-035 rst high: state IDLE, rr_ptr 0, grant 0, timeout counter 0, s_req 0, s_addr/s_we/s_wstrb/s_wdata 0, m_ack 0, m_err 0, m_rdata 0.
REQ-036 Reset in BUSY abandons the transaction; no ack/err issues afterwards; a late s_ack after reset is ignored per REQ-031.
REQ-037 First grant after reset favours master 0 among simultaneous requesters.

Verification
REQ-038 N_MST=2, master0 reads 0x1000, slave acks 2 cycles after s_req with rdata 0xDEADBEEF -> s_addr=0x1000; m_ack[0] pulses once; m_rdata=0xDEADBEEF; grant=0.
REQ-039 N_MST=4, all masters request continuously, slave acks immediately -> grants 0,1,2,3,0,... each separated by one DONE cycle.
REQ-040 TMO=8, slave never acks -> s_req high 8 cycles then low; m_err[grant] pulses once; next requester is granted.
REQ-041 TMO=8, s_ack exactly on the 8th BUSY cycle -> m_ack pulses; m_err stays low.
REQ-042 rst asserted mid-BUSY, then s_ack one cycle later -> all outputs zero; no m_ack; the next request is granted to master 0.
REQ-043 Write with wstrb=4'b0011 and wdata=0x12345678 from master1 while master0 changes its inputs -> s_* reflects master1's values unchanged until ack.
